mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single synchronous RAM port and the memory-mapped I/O (LED register, switch input) between two bus masters.
- Master 0 is the CPU load/store path. Master 1 is a secondary master (debug loader / DMA).
- Performs round-robin arbitration, address decode (RAM vs LED vs switches), and read/write sequencing with a registered acknowledge per master.
- Sits between the CPU and the RAM/IO instances in the top level, replacing the combinational mem_cmd decode.

Parameters:
ADDR_W, 9, bus address width
DATA_W, 16, bus data width
RAM_AW, 8, RAM address width (RAM occupies 0 .. 2^RAM_AW-1)
LED_ADDR, 9'h100, LED register address
SW_ADDR, 9'h140, switch input address
IO_W, 8, LED/switch field width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
m0_req  input  1  master 0 request; held until m0_ack sampled high
m0_write  input  1  1 = write, 0 = read; stable while m0_req=1
m0_addr  input  ADDR_W  master 0 address
m0_wdata  input  DATA_W  master 0 write data
m0_ack  output  1  one-cycle completion pulse
m0_rdata  output  DATA_W  read data; valid when m0_ack=1
m1_req, m1_write, m1_addr, m1_wdata, m1_ack, m1_rdata: same as the m0 ports, for master 1
ram_addr  output  RAM_AW  RAM address (registered)
ram_we  output  1  RAM write enable (registered)
ram_wdata  output  DATA_W  RAM write data (registered)
ram_rdata  input  DATA_W  RAM read data; valid the cycle after ram_addr is presented
sw_in  input  IO_W  switch inputs
ledr  output  IO_W  LED register

Behaviour:
- Reset (asynchronous, on any edge of reset including mid-transaction):
  - State = IDLE.
  - m0_ack, m1_ack, ram_we = 0.
  - ram_addr, ram_wdata, m0_rdata, m1_rdata, ledr = 0.
  - last_grant = 1, so master 0 wins the first tie.
  - An in-flight transaction is abandoned; no ack is issued.
- States: IDLE, RD_ADDR, RD_DATA, ACK.
- IDLE arbitration:
  - Only one request pending: that master wins.
  - Both pending: the master != last_grant wins.
  - The winner's write/addr/wdata are latched into internal registers at the grant edge.
  - No request pending: stay in IDLE, all strobes 0.
- Address decode (9-bit address):
  - RAM region: addr < 2^RAM_AW.
  - LED: addr == LED_ADDR.
  - SW: addr == SW_ADDR.
  - Anything else is unmapped.
- Transitions from IDLE at the grant edge:
  - RAM read: ram_addr <= addr[RAM_AW-1:0]; go to RD_ADDR.
  - RAM write: ram_addr <= addr, ram_wdata <= wdata, ram_we <= 1; go to ACK. The RAM commits at the end of the ACK cycle; ram_we is high for exactly one cycle.
  - LED write: ledr <= wdata[IO_W-1:0]; go to ACK.
  - LED read: rdata <= {0, ledr}; go to ACK.
  - SW read: rdata <= {0, sw_in}; go to ACK. sw_in is sampled at the grant edge.
  - SW write and unmapped write: dropped; go to ACK.
  - Unmapped read: rdata <= 16'h0000; go to ACK.
- RD_ADDR -> RD_DATA: unconditional, one cycle.
- RD_DATA -> ACK: the winner's rdata <= ram_rdata.
- ACK:
  - Winner's ack = 1 for exactly one cycle; the other master's ack stays 0.
  - last_grant <= winner.
  - Return to IDLE.
- The rdata register of the non-winning master holds its previous value.
- Latency, measured from the grant edge to the cycle in which ack is high:
  - 3 cycles for a RAM read.
  - 1 cycle for all other accesses.
  - The next grant occurs at the edge ending ACK + 1, i.e. one IDLE cycle between transactions.
- Requester rule: a master deasserts req (or presents a new request) at the edge where it samples ack = 1. An arbiter sampling a req that is still high in IDLE treats it as a new request.
- A request that arrives while the arbiter is busy waits; no request is ever lost.
- ledr holds its value until the next LED write or reset.

Test Plan:
- Reset → all outputs 0. m0 reads addr 9'h005 with RAM[5] = 16'h1234 → ram_addr = 5 after the grant edge; m0_ack high exactly 3 cycles after the grant; m0_rdata = 16'h1234; m1_ack stays 0.
- m1 writes 16'hBEEF to 9'h010 → ram_we = 1 for one cycle with ram_addr = 16'h10 and ram_wdata = 16'hBEEF; m1_ack one cycle after the grant. A following m1 read of 9'h010 returns 16'hBEEF.
- m0 and m1 both request continuously, immediately after reset → grants alternate m0, m1, m0, m1; each ack is a single-cycle pulse; no master is granted twice in a row while the other waits.
- sw_in = 8'h23, m0 reads 9'h140 → m0_rdata = 16'h0023. m0 writes 16'h0046 to 9'h100 → ledr = 8'h46. m0 reads 9'h100 → 16'h0046.
- m0 writes 16'h0040 to 9'h1FF (unmapped) → ack in 1 cycle; ram_we stays 0; ledr unchanged. m0 reads 9'h1FF → rdata = 16'h0000.
- Assert reset during RD_DATA of an m0 RAM read → m0_ack is never pulsed; state returns to IDLE; ledr = 0. After reset deasserts, a pending m1 request is granted first (last_grant = 1 with no tie → lone requester wins).

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master round-robin arbiter for the shared RAM port and LED/switch I/O
`timescale 1ns/1ps

module mem_bus_arbiter #(
  parameter int                ADDR_W   = 9,
  parameter int                DATA_W   = 16,
  parameter int                RAM_AW   = 8,
  parameter int                IO_W     = 8,
  parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR  = 9'h140
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [IO_W-1:0]   sw_in,
  output logic [IO_W-1:0]   ledr
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_ADDR = 2'd1,
    S_RD_DATA = 2'd2,
    S_ACK     = 2'd3
  } state_t;

  state_t              state_q;
  logic                last_grant_q;
  logic                win_q;
  logic                m0_ack_q;
  logic                m1_ack_q;
  logic [DATA_W-1:0]   m0_rdata_q;
  logic [DATA_W-1:0]   m1_rdata_q;
  logic [RAM_AW-1:0]   ram_addr_q;
  logic                ram_we_q;
  logic [DATA_W-1:0]   ram_wdata_q;
  logic [IO_W-1:0]     ledr_q;

  logic                gnt_valid;
  logic                gnt_sel;
  logic                sel_write;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_is_ram;
  logic                sel_is_led;
  logic                sel_is_sw;
  logic [DATA_W-1:0]   io_rdata;

  // On a tie the master that was not served last wins.
  always_comb begin
    gnt_valid = m0_req | m1_req;
    gnt_sel   = 1'b0;
    if (m0_req && m1_req) begin
      gnt_sel = ~last_grant_q;
    end else begin
      gnt_sel = m1_req;
    end
    sel_write  = gnt_sel ? m1_write : m0_write;
    sel_addr   = gnt_sel ? m1_addr  : m0_addr;
    sel_wdata  = gnt_sel ? m1_wdata : m0_wdata;
    sel_is_ram = (sel_addr[ADDR_W-1:RAM_AW] == '0);
    sel_is_led = (sel_addr == LED_ADDR);
    sel_is_sw  = (sel_addr == SW_ADDR);
    io_rdata   = '0;
    if (sel_is_led) begin
      io_rdata = {{(DATA_W-IO_W){1'b0}}, ledr_q};
    end else if (sel_is_sw) begin
      io_rdata = {{(DATA_W-IO_W){1'b0}}, sw_in};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      win_q        <= 1'b0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= '0;
      ledr_q       <= '0;
    end else begin
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      ram_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (gnt_valid) begin
            win_q <= gnt_sel;
            if (sel_is_ram && !sel_write) begin
              ram_addr_q <= sel_addr[RAM_AW-1:0];
              state_q    <= S_RD_ADDR;
            end else begin
              // Everything except a RAM read completes with the ack in the next cycle.
              if (sel_is_ram) begin
                ram_addr_q  <= sel_addr[RAM_AW-1:0];
                ram_wdata_q <= sel_wdata;
                ram_we_q    <= 1'b1;
              end else if (sel_write) begin
                if (sel_is_led) begin
                  ledr_q <= sel_wdata[IO_W-1:0];
                end
              end else if (gnt_sel) begin
                m1_rdata_q <= io_rdata;
              end else begin
                m0_rdata_q <= io_rdata;
              end
              if (gnt_sel) begin
                m1_ack_q <= 1'b1;
              end else begin
                m0_ack_q <= 1'b1;
              end
              state_q <= S_ACK;
            end
          end
        end
        S_RD_ADDR: begin
          state_q <= S_RD_DATA;
        end
        S_RD_DATA: begin
          if (win_q) begin
            m1_rdata_q <= ram_rdata;
            m1_ack_q   <= 1'b1;
          end else begin
            m0_rdata_q <= ram_rdata;
            m0_ack_q   <= 1'b1;
          end
          state_q <= S_ACK;
        end
        S_ACK: begin
          last_grant_q <= win_q;
          state_q      <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign ledr      = ledr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter with a transaction-level memory/IO model
`timescale 1ns/1ps

module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_write, m1_req, m1_write;
  logic [8:0]  m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [15:0] m0_rdata, m1_rdata;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic [7:0]  sw_in;
  logic [7:0]  ledr;

  mem_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .sw_in(sw_in), .ledr(ledr)
  );

  always #5 clk = ~clk;

  // Synchronous RAM the arbiter drives.
  logic [15:0] ram [256];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  typedef struct {
    bit          rd;
    logic [15:0] data;
    bit          chk_led;
    logic [7:0]  led;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] model_mem [256];
  logic [7:0]  model_led;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          we_count = 0;
  logic [7:0]  we_addr;
  logic [15:0] we_data;
  int          ack_order[$];
  int          m0_acks = 0;
  int          last_w = -1;
  bit          other_req_prev = 1'b0;
  bit          prev0 = 1'b0, prev1 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic on_ack(input int w);
    exp_t e;
    logic [15:0] rd;
    rd = (w == 1) ? m1_rdata : m0_rdata;
    chk($sformatf("m%0d_ack_pulse", w), (w == 1) ? prev1 : prev0, 0);
    if (last_w == w) chk("rr_fair", other_req_prev, 0);
    other_req_prev = (w == 1) ? m0_req : m1_req;
    last_w = w;
    ack_order.push_back(w);
    if (w == 0) m0_acks++;
    if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_ack m%0d: ack seen with no outstanding request", w);
    end else begin
      e = (w == 1) ? q1.pop_front() : q0.pop_front();
      if (e.rd) chk($sformatf("m%0d_rdata", w), rd, e.data);
      if (e.chk_led) chk("ledr_after_m0", ledr, e.led);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        last_w = -1;
        prev0 = 1'b0;
        prev1 = 1'b0;
      end else begin
        if (m0_ack && m1_ack) chk("dual_ack", 1, 0);
        if (m0_ack) on_ack(0);
        if (m1_ack) on_ack(1);
        if (ram_we) begin
          we_count++;
          we_addr = ram_addr;
          we_data = ram_wdata;
        end
        prev0 = m0_ack;
        prev1 = m1_ack;
      end
    end
  end

  task automatic drive(input int m, input bit req, input bit wr, input logic [8:0] a, input logic [15:0] d);
    if (m == 0) begin
      m0_req = req; m0_write = wr; m0_addr = a; m0_wdata = d;
    end else begin
      m1_req = req; m1_write = wr; m1_addr = a; m1_wdata = d;
    end
  endtask

  // Expected outcome comes from the address map applied to the model, then the request is held until ack.
  task automatic xact(input int m, input bit wr, input logic [8:0] a, input logic [15:0] d, output int cyc);
    exp_t e;
    e.rd = !wr;
    e.data = 16'h0000;
    e.chk_led = (m == 0);
    if (a < 9'h100) begin
      if (wr) model_mem[a[7:0]] = d;
      else e.data = model_mem[a[7:0]];
    end else if (a == 9'h100) begin
      if (wr) model_led = d[7:0];
      else e.data = {8'h00, model_led};
    end else if (a == 9'h140) begin
      if (!wr) e.data = {8'h00, sw_in};
    end
    e.led = model_led;
    if (m == 0) q0.push_back(e); else q1.push_back(e);
    @(posedge clk);
    #1;
    drive(m, 1'b1, wr, a, d);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!((m == 1) ? m1_ack : m0_ack) && cyc < 40);
    if (cyc >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout m%0d addr %h: no ack within 40 cycles", m, a);
    end
  endtask

  task automatic idle(input int m, input int k);
    @(posedge clk);
    #1;
    drive(m, 1'b0, 1'b0, 9'h000, 16'h0000);
    repeat (k) @(posedge clk);
  endtask

  function automatic logic [8:0] unmapped_addr();
    case ($urandom_range(0, 3))
      0:       return 9'h1FF;
      1:       return 9'h180;
      2:       return 9'h101;
      default: return 9'h13F;
    endcase
  endfunction

  task automatic rand_master(input int m, input int n);
    int c;
    int r;
    logic [8:0] a;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      a = {1'b0, 7'($urandom_range(0, 127)), 1'(m)};
      if (r <= 4) xact(m, 1'($urandom_range(0, 1)), a, 16'($urandom), c);
      else if (r == 5 && m == 0) xact(m, 1'b1, 9'h100, 16'($urandom), c);
      else if (r == 6 && m == 0) xact(m, 1'b0, 9'h100, 16'h0000, c);
      else if (r == 7) xact(m, 1'b0, 9'h140, 16'h0000, c);
      else if (r == 8) xact(m, 1'($urandom_range(0, 1)), unmapped_addr(), 16'($urandom), c);
      else xact(m, 1'b1, 9'h140, 16'($urandom), c);
      if ($urandom_range(0, 2) == 0) idle(m, $urandom_range(0, 3));
    end
    idle(m, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c;
    int we0;
    int acks0;
    logic [15:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 16'(i * 16'h0101) ^ 16'hA5C3;
      ram[i] = v;
      model_mem[i] = v;
    end
    ram[5] = 16'h1234;
    model_mem[5] = 16'h1234;
    model_led = 8'h00;
    reset = 1'b1;
    sw_in = 8'h00;
    drive(0, 1'b0, 1'b0, 9'h000, 16'h0000);
    drive(1, 1'b0, 1'b0, 9'h000, 16'h0000);
    repeat (2) @(negedge clk);
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_m1_ack", m1_ack, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    chk("rst_ledr", ledr, 0);
    #1 reset = 1'b0;

    // Both masters request back-to-back straight out of reset.
    ack_order.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) xact(0, 1'($urandom_range(0, 1)), {1'b0, 7'(i + 64), 1'b0}, 16'($urandom), c);
        idle(0, 0);
      end
      begin
        for (int i = 0; i < 4; i++) xact(1, 1'($urandom_range(0, 1)), {1'b0, 7'(i + 64), 1'b1}, 16'($urandom), c);
        idle(1, 0);
      end
    join
    #1;
    chk("alt_count", ack_order.size(), 8);
    for (int i = 0; i < ack_order.size() && i < 8; i++) chk($sformatf("alt_order_%0d", i), ack_order[i], i % 2);
    idle(0, 2);

    xact(0, 1'b0, 9'h005, 16'h0000, c);
    #1;
    chk("ram_rd_latency", c, 4);
    chk("ram_rd_addr", ram_addr, 8'h05);
    chk("ram_rd_data", m0_rdata, 16'h1234);
    idle(0, 1);

    we0 = we_count;
    xact(1, 1'b1, 9'h010, 16'hBEEF, c);
    #1;
    chk("ram_wr_latency", c, 2);
    chk("ram_we_cycles", we_count - we0, 1);
    chk("ram_we_addr", we_addr, 8'h10);
    chk("ram_we_data", we_data, 16'hBEEF);
    xact(1, 1'b0, 9'h010, 16'h0000, c);
    #1;
    chk("ram_rb_data", m1_rdata, 16'hBEEF);
    idle(1, 1);

    sw_in = 8'h23;
    xact(0, 1'b0, 9'h140, 16'h0000, c);
    #1;
    chk("sw_rd_latency", c, 2);
    chk("sw_rd_data", m0_rdata, 16'h0023);
    xact(0, 1'b1, 9'h100, 16'h0046, c);
    #1;
    chk("led_wr", ledr, 8'h46);
    xact(0, 1'b0, 9'h100, 16'h0000, c);
    #1;
    chk("led_rd", m0_rdata, 16'h0046);

    we0 = we_count;
    xact(0, 1'b1, 9'h1FF, 16'h0040, c);
    #1;
    chk("unmapped_wr_latency", c, 2);
    chk("unmapped_wr_no_we", we_count - we0, 0);
    chk("unmapped_wr_ledr", ledr, 8'h46);
    xact(0, 1'b0, 9'h1FF, 16'h0000, c);
    #1;
    chk("unmapped_rd", m0_rdata, 16'h0000);
    idle(0, 2);

    // Reset lands while an m0 RAM read sits in RD_DATA; m1 is waiting when it releases.
    acks0 = m0_acks;
    @(posedge clk);
    #1;
    drive(0, 1'b1, 1'b0, 9'h020, 16'h0000);
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b1;
    model_led = 8'h00;
    drive(0, 1'b0, 1'b0, 9'h000, 16'h0000);
    begin
      exp_t e;
      e.rd = 1'b1;
      e.data = model_mem[8'h31];
      e.chk_led = 1'b0;
      e.led = 8'h00;
      q1.push_back(e);
    end
    drive(1, 1'b1, 1'b0, 9'h031, 16'h0000);
    @(negedge clk);
    chk("midrst_m0_ack", m0_ack, 0);
    chk("midrst_ledr", ledr, 0);
    chk("midrst_ram_addr", ram_addr, 0);
    #1 reset = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!m1_ack && c < 40);
    #1;
    chk("post_rst_m1_latency", c, 3);
    chk("post_rst_no_m0_ack", m0_acks - acks0, 0);
    chk("post_rst_ledr", ledr, 0);
    idle(1, 2);

    sw_in = 8'($urandom);
    fork
      rand_master(0, 150);
      rand_master(1, 150);
    join
    repeat (4) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
